// File: rtl/mii_frame_serializer.sv
// Serializes one captured Ethernet frame onto a 64-bit XGMII-style TX interface:
// /S/ on lane 0 of the first word, /T/ after the last FCS byte, then an idle gap.
module mii_frame_serializer #(
  parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
  parameter int unsigned IPG_WORDS        = 1
) (
  input  logic                                 clk,
  input  logic                                 i_rst_n,
  input  logic [(PAYLOAD_MAX_SIZE+26)*8-1:0]   i_register,
  input  logic [15:0]                          i_payload_length,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  output logic [63:0]                          o_txd,
  output logic [7:0]                           o_txc,
  output logic                                 o_frame_done
);

  localparam int unsigned W         = (PAYLOAD_MAX_SIZE + 26) * 8;
  localparam int unsigned LEN_W     = $clog2(PAYLOAD_MAX_SIZE + 27);
  localparam int unsigned N_MAX     = (PAYLOAD_MAX_SIZE + 26) / 8;
  localparam int unsigned CNT_W_RAW = $clog2(N_MAX + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 8) ? 8 : CNT_W_RAW;
  localparam int unsigned GAP_W     = (IPG_WORDS > 1) ? $clog2(IPG_WORDS) : 1;
  localparam logic [63:0] IDLE_WORD = {8{8'h07}};

  typedef enum logic [1:0] {S_IDLE, S_XMIT, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [W-1:0]       r_buf;
  logic [CNT_W-1:0]   r_word, w_word_nxt;
  logic [CNT_W-1:0]   r_last_word;
  logic [2:0]         r_last_lane;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [63:0]        w_txd_nxt, w_data;
  logic [7:0]         w_txc_nxt;
  logic               w_ready_nxt, w_done_nxt;
  logic               w_load, w_shift;
  logic [15:0]        w_plen;
  logic [LEN_W-1:0]   w_len;

  // Clamp the payload length, then frame length L = payload + 26
  assign w_plen = (i_payload_length > 16'(PAYLOAD_MAX_SIZE)) ? 16'(PAYLOAD_MAX_SIZE)
                                                             : i_payload_length;
  assign w_len  = LEN_W'(w_plen) + LEN_W'(26);

  // Buffer is shifted a word per XMIT cycle, so the current word is always on top
  always_comb begin
    w_data = '0;
    for (int j = 0; j < 8; j++) begin
      w_data[8*j +: 8] = r_buf[W-1-8*j -: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_gap_nxt   = r_gap;
    w_txd_nxt   = IDLE_WORD;
    w_txc_nxt   = 8'hFF;
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (i_valid && o_ready) begin
          w_load      = 1'b1;
          w_word_nxt  = '0;
          w_ready_nxt = 1'b0;
          w_state_nxt = S_XMIT;
        end
      end
      S_XMIT: begin
        w_shift    = 1'b1;
        w_word_nxt = r_word + CNT_W'(1);
        w_txd_nxt  = w_data;
        w_txc_nxt  = 8'h00;
        if (r_word == '0) begin
          w_txd_nxt[7:0] = 8'hFB;
          w_txc_nxt      = 8'h01;
        end
        if (r_word == r_last_word) begin
          for (int j = 0; j < 8; j++) begin
            if (3'(j) == r_last_lane) begin
              w_txd_nxt[8*j +: 8] = 8'hFD;
            end else if (3'(j) > r_last_lane) begin
              w_txd_nxt[8*j +: 8] = 8'h07;
            end
          end
          w_txc_nxt   = 8'hFF << r_last_lane;
          w_done_nxt  = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap + GAP_W'(1);
        if (r_gap == GAP_W'(IPG_WORDS - 1)) begin
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_gap        <= '0;
      o_txd        <= IDLE_WORD;
      o_txc        <= 8'hFF;
      o_ready      <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_gap        <= w_gap_nxt;
      o_txd        <= w_txd_nxt;
      o_txc        <= w_txc_nxt;
      o_ready      <= w_ready_nxt;
      o_frame_done <= w_done_nxt;
    end
  end

  // Frame capture: buffer plus terminate position (word N, lane m)
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf       <= '0;
      r_last_word <= '0;
      r_last_lane <= '0;
    end else if (w_load) begin
      r_buf       <= i_register;
      r_last_word <= CNT_W'(w_len[LEN_W-1:3]);
      r_last_lane <= w_len[2:0];
    end else if (w_shift) begin
      r_buf       <= r_buf << 64;
    end
  end

endmodule

// File: tb/tb_mii_frame_serializer.sv
// Directed bench for mii_frame_serializer: table of hand-computed words plus
// sequences for busy drop, mid-frame reset, clamp and back-to-back spacing.
module tb_mii_frame_serializer;

  localparam int unsigned PMAX = 1500;
  localparam int unsigned W    = (PMAX + 26) * 8;
  localparam logic [63:0] IDLE_W = {8{8'h07}};

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [W-1:0]  i_register;
  logic [15:0]   i_payload_length;
  logic          i_valid1, i_valid3;
  logic          o_ready1, o_ready3;
  logic [63:0]   o_txd1, o_txd3;
  logic [7:0]    o_txc1, o_txc3;
  logic          o_done1, o_done3;

  always #5 clk = ~clk;

  mii_frame_serializer #(.PAYLOAD_MAX_SIZE(PMAX), .IPG_WORDS(1)) dut1 (
    .clk(clk), .i_rst_n(i_rst_n), .i_register(i_register),
    .i_payload_length(i_payload_length), .i_valid(i_valid1), .o_ready(o_ready1),
    .o_txd(o_txd1), .o_txc(o_txc1), .o_frame_done(o_done1));

  mii_frame_serializer #(.PAYLOAD_MAX_SIZE(PMAX), .IPG_WORDS(3)) dut3 (
    .clk(clk), .i_rst_n(i_rst_n), .i_register(i_register),
    .i_payload_length(i_payload_length), .i_valid(i_valid3), .o_ready(o_ready3),
    .o_txd(o_txd3), .o_txc(o_txc3), .o_frame_done(o_done3));

  typedef struct {
    int          plen;
    int          word;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        done;
    int          nwords;
  } tv_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  fb [0:PMAX+25];
  logic [63:0] cap_txd [0:255];
  logic [7:0]  cap_txc [0:255];
  logic        cap_done [0:255];
  int          ncap;
  int          gap_idles;
  tv_t         vec [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Frame bytes: preamble/SFD, DA FF.., SA 11..66, length, payload i -> i, FCS DE AD BE EF
  task automatic build(input int plen);
    int cl, len;
    logic [W-1:0] rv;
    cl  = (plen > int'(PMAX)) ? int'(PMAX) : plen;
    len = cl + 26;
    for (int k = 0; k < 7; k++) fb[k] = 8'h55;
    fb[7] = 8'hD5;
    for (int k = 8; k < 14; k++) fb[k] = 8'hFF;
    for (int k = 14; k < 20; k++) fb[k] = 8'(8'h11 * (k - 13));
    fb[20] = 8'(plen >> 8);
    fb[21] = 8'(plen);
    for (int i = 0; i < cl; i++) fb[22+i] = 8'(i);
    fb[22+cl] = 8'hDE; fb[23+cl] = 8'hAD; fb[24+cl] = 8'hBE; fb[25+cl] = 8'hEF;
    rv = '0;
    for (int k = 0; k < len; k++) rv[W-1-8*k -: 8] = fb[k];
    i_register       = rv;
    i_payload_length = 16'(plen);
  endtask

  function automatic logic [63:0] model_txd(input int n, input int len);
    logic [63:0] w;
    int b, m;
    m = len % 8;
    for (int j = 0; j < 8; j++) begin
      b = 8*n + j;
      w[8*j +: 8] = (b < len) ? fb[b] : 8'h00;
      if (n == len/8 && j == m) w[8*j +: 8] = 8'hFD;
      if (n == len/8 && j > m)  w[8*j +: 8] = 8'h07;
    end
    if (n == 0) w[7:0] = 8'hFB;
    return w;
  endfunction

  function automatic logic [7:0] model_txc(input int n, input int len);
    if (n == 0) return 8'h01;
    if (n == len/8) return 8'hFF << (len % 8);
    return 8'h00;
  endfunction

  // Launch one frame on dut1, capture all words through o_frame_done, then count gap idles
  task automatic run_frame(input int plen, input int poke_at);
    int  cnt;
    bit  got_done;
    @(negedge clk);
    build(plen);
    cnt = 0;
    while (!o_ready1 && cnt < 500) begin @(negedge clk); cnt++; end
    if (!o_ready1) chk("ready_timeout", 64'(o_ready1), 64'(1));
    i_valid1 = 1'b1;
    @(negedge clk);
    i_valid1 = 1'b0;
    chk("prestart_idle", o_txd1, IDLE_W);
    chk("prestart_busy", 64'(o_ready1), 64'(0));
    ncap = 0;
    got_done = 1'b0;
    for (int c = 0; c < 256 && !got_done; c++) begin
      @(negedge clk);
      cap_txd[ncap]  = o_txd1;
      cap_txc[ncap]  = o_txc1;
      cap_done[ncap] = o_done1;
      ncap++;
      got_done = o_done1;
      i_valid1 = 1'b0;
      if (c == poke_at) begin
        build(128);
        i_valid1 = 1'b1;
      end
    end
    i_valid1 = 1'b0;
    if (!got_done) chk("frame_done_timeout", 64'(got_done), 64'(1));
    gap_idles = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      if (o_txd1 == IDLE_W && o_txc1 == 8'hFF) gap_idles++;
      cnt++;
    end while (!o_ready1 && cnt < 20);
  endtask

  task automatic check_full(input string tag, input int plen);
    int len;
    len = plen + 26;
    build(plen);
    chk({tag, "_nwords"}, 64'(ncap), 64'(len/8 + 1));
    for (int n = 0; n < ncap && n < len/8 + 1; n++) begin
      chk($sformatf("%s_txd%0d", tag, n), cap_txd[n], model_txd(n, len));
      chk($sformatf("%s_txc%0d", tag, n), 64'(cap_txc[n]), 64'(model_txc(n, len)));
    end
  endtask

  initial begin
    int last, bad, starts, idles;
    bit seen_done;

    vec[0] = '{64,   0,   64'hD5555555555555FB, 8'h01, 1'b0, 12};
    vec[1] = '{64,   1,   64'h2211FFFFFFFFFFFF, 8'h00, 1'b0, 12};
    vec[2] = '{64,   2,   64'h0100400066554433, 8'h00, 1'b0, 12};
    vec[3] = '{64,   10,  64'hADDE3F3E3D3C3B3A, 8'h00, 1'b0, 12};
    vec[4] = '{64,   11,  64'h0707070707FDEFBE, 8'hFC, 1'b1, 12};
    vec[5] = '{6,    3,   64'hEFBEADDE05040302, 8'h00, 1'b0, 5};
    vec[6] = '{6,    4,   64'h07070707070707FD, 8'hFF, 1'b1, 5};
    vec[7] = '{13,   4,   64'hFDEFBEADDE0C0B0A, 8'h80, 1'b1, 5};
    vec[8] = '{0,    3,   64'h0707070707FDEFBE, 8'hFC, 1'b1, 4};
    vec[9] = '{2000, 190, 64'h07FDEFBEADDEDBDA, 8'hC0, 1'b1, 191};

    i_rst_n  = 1'b0;
    i_valid1 = 1'b0;
    i_valid3 = 1'b0;
    build(64);
    repeat (3) @(negedge clk);
    chk("rst_txd", o_txd1, IDLE_W);
    chk("rst_txc", 64'(o_txc1), 64'hFF);
    chk("rst_ready", 64'(o_ready1), 64'(1));
    chk("rst_done", 64'(o_done1), 64'(0));
    i_rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_done1 || o_txd1 != IDLE_W || o_txc1 != 8'hFF || !o_ready1) bad++;
    end
    chk("idle_after_rst", 64'(bad), 64'(0));

    last = -1;
    foreach (vec[i]) begin
      if (vec[i].plen != last) begin
        run_frame(vec[i].plen, -1);
        chk($sformatf("gap_idles_p%0d", vec[i].plen), 64'(gap_idles), 64'(1));
        last = vec[i].plen;
      end
      chk($sformatf("v%0d_nwords", i), 64'(ncap), 64'(vec[i].nwords));
      chk($sformatf("v%0d_txd", i), cap_txd[vec[i].word], vec[i].txd);
      chk($sformatf("v%0d_txc", i), 64'(cap_txc[vec[i].word]), 64'(vec[i].txc));
      chk($sformatf("v%0d_done", i), 64'(cap_done[vec[i].word]), 64'(vec[i].done));
    end

    // Busy drop: a 128-byte frame offered during XMIT must be ignored
    run_frame(64, 3);
    check_full("busy", 64);
    chk("busy_gap", 64'(gap_idles), 64'(1));
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (o_txd1 != IDLE_W || o_txc1 != 8'hFF) bad++;
    end
    chk("busy_no_second", 64'(bad), 64'(0));

    // Reset at word 5 of a 64-byte frame
    build(64);
    i_valid1 = 1'b1;
    @(negedge clk);
    i_valid1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_word5", o_txd1, model_txd(5, 90));
    i_rst_n = 1'b0;
    #1;
    chk("midrst_txd", o_txd1, IDLE_W);
    chk("midrst_txc", 64'(o_txc1), 64'hFF);
    chk("midrst_ready", 64'(o_ready1), 64'(1));
    @(negedge clk);
    i_rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (o_txd1 != IDLE_W || o_txc1 != 8'hFF || o_done1) bad++;
    end
    chk("midrst_no_fd", 64'(bad), 64'(0));
    run_frame(64, -1);
    check_full("after_rst", 64);

    // Back-to-back on IPG_WORDS=3 instance with i_valid held high
    @(negedge clk);
    build(6);
    i_valid3  = 1'b1;
    seen_done = 1'b0;
    starts    = 0;
    idles     = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o_txc3[0] && o_txd3[7:0] == 8'hFB) begin
        starts++;
        chk($sformatf("b2b_start%0d", starts), o_txd3, 64'hD5555555555555FB);
        if (seen_done) chk($sformatf("b2b_gap%0d", starts), 64'(idles), 64'(4));
        seen_done = 1'b0;
      end else if (seen_done && o_txd3 == IDLE_W && o_txc3 == 8'hFF) begin
        idles++;
      end
      if (o_done3) begin
        seen_done = 1'b1;
        idles     = 0;
      end
    end
    i_valid3 = 1'b0;
    chk("b2b_frames", 64'(starts >= 5), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mii_frame_serializer.md
# mii_frame_serializer

Stage directly downstream of `mac_frame_generator`. It captures one flat frame register when the generator signals done, then serializes it onto a 64-bit XGMII-style TX interface. The serializer puts /S/ on lane 0, emits data words, places /T/ after the last FCS byte and fills the rest of the word with /I/. It then enforces an idle gap before it accepts the next frame.

## Interface
- `PAYLOAD_MAX_SIZE`, default 1500: maximum payload bytes; must match the generator.
- `IPG_WORDS`, default 1: minimum full idle words after the terminate word (minimum value 1).
- `clk`, input, 1: single clock, rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_register`, input, (PAYLOAD_MAX_SIZE+26)*8: generator frame (preamble/SFD, DA, SA, length, payload, FCS).
  - Byte k is at bits [W-1-8k -: 8], where W is the register width.
- `i_payload_length`, input, 16: payload bytes for the presented frame.
- `i_valid`, input, 1: frame-present strobe (generator `o_done`).
- `o_ready`, output, 1: a frame can be accepted this cycle.
- `o_txd`, output, 64: TX data; lane n is bits [8n+7:8n], and lane 0 goes first.
- `o_txc`, output, 8: TX control; bit n=1 means lane n carries a control character.
- `o_frame_done`, output, 1: one-cycle pulse coincident with the terminate word.

## Operation
- Frame length L = i_payload_length + 26 bytes.
  - i_payload_length > PAYLOAD_MAX_SIZE is clamped to PAYLOAD_MAX_SIZE.
  - No padding is added here; minimum-size padding belongs to the generator.
- Acceptance happens on a rising edge where `i_valid` and `o_ready` are both 1.
  - The serializer latches `i_register` into an internal buffer and latches the clamped L.
  - `i_valid` while `o_ready`=0 is ignored. No queueing, no error flag.
- States:
  - IDLE: `o_ready`=1, idle words.
  - XMIT: word index n runs from 0 to N=floor(L/8).
  - GAP: counts IPG_WORDS idle words, then returns to IDLE.
- Word n carries buffer bytes 8n..8n+7 on lanes 0..7, with these substitutions:
  - Word 0, lane 0: replaced by /S/ 0xFB, txc bit 0 = 1. Lanes 1-7 carry the preamble/SFD bytes unchanged (0x55 ×6, 0xD5).
  - Word N: lanes below m = L mod 8 carry data. Lane m = /T/ 0xFD. Lanes above m = /I/ 0x07. txc = 0xFF << m.
  - All other XMIT words: txc = 0x00.
  - When m = 0, word N is 0x07070707070707FD with txc = 0xFF.
- Idle word: `o_txd` = 0x0707070707070707, `o_txc` = 0xFF.
- Reset values: `o_txd` = idle word, `o_txc` = 0xFF, `o_ready` = 1, `o_frame_done` = 0, state IDLE, counters 0.
- Reset asserted mid-frame: outputs return to idle asynchronously. The frame is abandoned, no /T/ is emitted, and the buffer is discarded.

## Timing
- All outputs are registered.
- Frame accepted on edge k:
  - `o_ready` goes 0 after edge k.
  - Word 0 appears after edge k+1.
  - Word n appears after edge k+1+n.
  - The terminate word and `o_frame_done`=1 appear after edge k+1+N.
- GAP words appear after edges k+2+N .. k+1+N+IPG_WORDS.
- `o_ready` returns to 1 after edge k+1+N+IPG_WORDS; the earliest next acceptance is on the following edge.
- The cycle between acceptance and word 0 outputs an idle word.
- Back-to-back frames are therefore separated by at least IPG_WORDS idle words plus the /I/ lanes of the terminate word.
- Word count per frame: N+1 = floor(L/8)+1. Word counter width is at least 8 bits (max N = 190).
- Inputs are sampled only on the acceptance edge. `i_register` may change afterwards without effect.

## Test plan
- Reset / idle:
  - Stimulus: assert `i_rst_n`=0, then release with `i_valid`=0.
  - Required response: `o_txd` = 0x0707070707070707, `o_txc` = 0xFF, `o_ready` = 1, `o_frame_done` never pulses.
- Payload 64 (L=90, N=11), DA FF:FF:FF:FF:FF:FF, SA 11:22:33:44:55:66:
  - Word 0 = 0xD5555555555555FB with txc 0x01.
  - Word 1 lanes 0-5 = FF, lanes 6-7 = 11, 22.
  - Word 11: lanes 0-1 = FCS bytes 88-89, lane 2 = FD, txc 0xFC, `o_frame_done`=1 on that cycle.
  - Exactly one idle word follows before `o_ready`=1.
- Payload 6 (L=32):
  - Word 4 = 0x07070707070707FD with txc 0xFF.
  - Payload 13 (L=39): word 4 lane 7 = FD, txc 0x80.
- Busy drop:
  - Stimulus: pulse `i_valid` with payload 128 during XMIT of a 64-byte frame.
  - Required response: second frame ignored; the first frame completes unchanged; no second /S/.
- Back-to-back, IPG_WORDS=3:
  - Stimulus: hold `i_valid`=1 continuously.
  - Required response: frames separated by exactly 3 idle words plus one pre-start idle word. Each frame starts with 0xFB on lane 0.
- Reset mid-frame and clamp:
  - Stimulus: assert `i_rst_n` at word 5 of a 64-byte frame.
  - Required response: immediate idle outputs, `o_ready`=1, no FD emitted. A subsequent frame serializes correctly.
  - Stimulus: i_payload_length = 2000.
  - Required response: treated as 1500 (L=1526, N=190, T on lane 6).
